// File: rtl/pt_feedback_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pt_feedback_pkg
// Description : Shared types and default sizes for the pt_feedback datapath.
//               Holds the pulse sequencer state encoding and the default
//               counter/repeat widths used as parameter defaults.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pt_feedback_pkg;

  localparam int c_CNT_W_DEF = 32;
  localparam int c_RPT_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_DELAY = 3'd2,
    S_HIGH  = 3'd3,
    S_LOW   = 3'd4
  } state_e;

endpackage : pt_feedback_pkg
`default_nettype wire

// File: rtl/edge_detector.sv
`default_nettype none
// ============================================================================
// Module      : edge_detector
// Description : Rising-edge detector for a level that is already synchronous
//               to clk_i. The rise flag is combinational: it is high in the
//               same cycle the input is first seen high.
// Ports       : clk_i   - system clock
//               rst_ni  - asynchronous active-low reset
//               i_sig   - level to watch
//               o_rise  - high for the first cycle i_sig is 1 after a 0
// Revision    : 1.0 - initial release
// ============================================================================
module edge_detector (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;

  // Previous-cycle copy of the level; cleared by reset so a level already
  // high when reset releases reads as a rise on the first cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_prev;

endmodule : edge_detector
`default_nettype wire

// File: rtl/pulse_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pulse_sequencer
// Description : Armed, trigger-driven pulse scheduler. Once armed, a rising
//               edge on trig_i starts a programmable delay followed by a
//               train of pulses (width, period, count). Configuration is
//               captured at the trigger so the running train is immune to
//               later register-bank writes.
// Ports       : clk_i    - system clock
//               rst_ni   - asynchronous active-low reset
//               trig_i   - trigger level (synchronous to clk_i)
//               arm_i    - one-cycle arm request
//               abort_i  - abort, highest priority
//               delay_i  - cycles from trigger edge to first pulse
//               width_i  - pulse high time (0 behaves as 1)
//               period_i - pulse repetition period
//               count_i  - number of pulses (0 behaves as 1)
//               pulse_o  - pulse train output
//               armed_o  - waiting for a trigger edge
//               busy_o   - from accepted trigger until the train ends
//               done_o   - one-cycle strobe after the last pulse
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_sequencer
  import pt_feedback_pkg::*;
#(
  parameter int CNT_W = c_CNT_W_DEF,
  parameter int RPT_W = c_RPT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             trig_i,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] delay_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [RPT_W-1:0] count_i,
  output logic             pulse_o,
  output logic             armed_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [RPT_W-1:0] c_RPT_ZERO = '0;
  localparam logic [RPT_W-1:0] c_RPT_ONE  = RPT_W'(1);

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;      // cycles left in current phase, minus one
  logic [RPT_W-1:0] r_rep;      // pulses still to emit, including current
  logic [CNT_W-1:0] r_wid_m1;   // shadow: HIGH length minus one
  logic [CNT_W-1:0] r_low_m1;   // shadow: LOW length minus one
  logic             r_done;

  state_e           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [RPT_W-1:0] w_rep_nxt;
  logic [CNT_W-1:0] w_wid_m1_nxt;
  logic [CNT_W-1:0] w_low_m1_nxt;
  logic             w_done_nxt;

  // --------------------------------------------------------------------------
  // Trigger edge
  // --------------------------------------------------------------------------
  logic w_pe;

  edge_detector u_trig_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_sig  (trig_i),
    .o_rise (w_pe)
  );

  // --------------------------------------------------------------------------
  // Configuration as it would be captured at a trigger
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] w_cfg_wid;
  logic [CNT_W-1:0] w_cfg_wid_m1;
  logic [CNT_W-1:0] w_cfg_low;
  logic [CNT_W-1:0] w_cfg_low_m1;
  logic [RPT_W-1:0] w_cfg_rep;

  assign w_cfg_wid    = (width_i == c_CNT_ZERO) ? c_CNT_ONE : width_i;
  assign w_cfg_wid_m1 = w_cfg_wid - c_CNT_ONE;
  // The gap saturates at one cycle so back-to-back pulses never merge even
  // when the period is not longer than the pulse.
  assign w_cfg_low    = (period_i > w_cfg_wid) ? (period_i - w_cfg_wid) : c_CNT_ONE;
  assign w_cfg_low_m1 = w_cfg_low - c_CNT_ONE;
  assign w_cfg_rep    = (count_i == c_RPT_ZERO) ? c_RPT_ONE : count_i;

  // --------------------------------------------------------------------------
  // State register and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_cnt    <= c_CNT_ZERO;
      r_rep    <= c_RPT_ZERO;
      r_wid_m1 <= c_CNT_ZERO;
      r_low_m1 <= c_CNT_ZERO;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rep    <= w_rep_nxt;
      r_wid_m1 <= w_wid_m1_nxt;
      r_low_m1 <= w_low_m1_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_rep_nxt    = r_rep;
    w_wid_m1_nxt = r_wid_m1;
    w_low_m1_nxt = r_low_m1;
    w_done_nxt   = 1'b0;

    if (abort_i) begin
      // Abort overrides everything, including a same-cycle arm or trigger.
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = c_CNT_ZERO;
      w_rep_nxt   = c_RPT_ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A trigger edge coinciding with arm is not seen: pe is only
          // consulted once the ARMED state is registered.
          if (arm_i) begin
            w_state_nxt = S_ARMED;
          end
        end

        S_ARMED: begin
          if (w_pe) begin
            w_wid_m1_nxt = w_cfg_wid_m1;
            w_low_m1_nxt = w_cfg_low_m1;
            w_rep_nxt    = w_cfg_rep;
            if (delay_i == c_CNT_ZERO) begin
              w_state_nxt = S_HIGH;
              w_cnt_nxt   = w_cfg_wid_m1;
            end else begin
              w_state_nxt = S_DELAY;
              w_cnt_nxt   = delay_i - c_CNT_ONE;
            end
          end
        end

        S_DELAY: begin
          if (r_cnt == c_CNT_ZERO) begin
            w_state_nxt = S_HIGH;
            w_cnt_nxt   = r_wid_m1;
          end else begin
            w_cnt_nxt = r_cnt - c_CNT_ONE;
          end
        end

        S_HIGH: begin
          if (r_cnt == c_CNT_ZERO) begin
            if (r_rep > c_RPT_ONE) begin
              w_state_nxt = S_LOW;
              w_cnt_nxt   = r_low_m1;
              w_rep_nxt   = r_rep - c_RPT_ONE;
            end else begin
              w_state_nxt = S_IDLE;
              w_rep_nxt   = c_RPT_ZERO;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt - c_CNT_ONE;
          end
        end

        S_LOW: begin
          if (r_cnt == c_CNT_ZERO) begin
            w_state_nxt = S_HIGH;
            w_cnt_nxt   = r_wid_m1;
          end else begin
            w_cnt_nxt = r_cnt - c_CNT_ONE;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = c_CNT_ZERO;
          w_rep_nxt   = c_RPT_ZERO;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs decode the registered state, so async reset clears them at once.
  // --------------------------------------------------------------------------
  assign pulse_o = (r_state == S_HIGH);
  assign armed_o = (r_state == S_ARMED);
  assign busy_o  = (r_state == S_DELAY) || (r_state == S_HIGH) || (r_state == S_LOW);
  assign done_o  = r_done;

endmodule : pulse_sequencer
`default_nettype wire

// File: tb/tb_pulse_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_sequencer
// Description : Self-checking bench for pulse_sequencer. A timeline model
//               derives expected outputs arithmetically from the captured
//               trigger time and configuration; directed trains are also
//               pinned against hand-computed pulse/done bit patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_sequencer;

  localparam int CNT_W = 32;
  localparam int RPT_W = 16;
  localparam int HMAX  = 16384;

  logic             clk_i    = 1'b0;
  logic             rst_ni   = 1'b0;
  logic             trig_i   = 1'b0;
  logic             arm_i    = 1'b0;
  logic             abort_i  = 1'b0;
  logic [CNT_W-1:0] delay_i  = '0;
  logic [CNT_W-1:0] width_i  = '0;
  logic [CNT_W-1:0] period_i = '0;
  logic [RPT_W-1:0] count_i  = '0;
  logic             pulse_o;
  logic             armed_o;
  logic             busy_o;
  logic             done_o;

  pulse_sequencer #(.CNT_W(CNT_W), .RPT_W(RPT_W)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .trig_i   (trig_i),
    .arm_i    (arm_i),
    .abort_i  (abort_i),
    .delay_i  (delay_i),
    .width_i  (width_i),
    .period_i (period_i),
    .count_i  (count_i),
    .pulse_o  (pulse_o),
    .armed_o  (armed_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Timeline model: a train is described by its first busy cycle, delay,
  // pulse width, pulse pitch and end cycle.
  bit     m_prev;
  bit     m_armed;
  bit     m_active;
  longint m_s, m_d, m_wm, m_pp, m_e, m_done;

  bit h_pulse [HMAX];
  bit h_done  [HMAX];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_prev   = 1'b0;
    m_armed  = 1'b0;
    m_active = 1'b0;
    m_s = 0; m_d = 0; m_wm = 1; m_pp = 2; m_e = 0;
    m_done   = -1;
  endtask

  function automatic bit exp_pulse(int c);
    longint t;
    if (!m_active || longint'(c) < m_s + m_d) return 1'b0;
    t = longint'(c) - (m_s + m_d);
    return (t % m_pp) < m_wm;
  endfunction

  // Advance one clock: evaluate the model on the inputs present in cycle
  // cyc, clock the DUT, then compare outputs for the new cycle.
  task automatic step();
    bit     pe;
    longint n, lo, per;
    pe = trig_i && !m_prev;
    if (abort_i) begin
      m_armed  = 1'b0;
      m_active = 1'b0;
    end else if (m_active) begin
      m_active = 1'b1;  // running train ignores arm and trigger
    end else if (m_armed) begin
      if (pe) begin
        m_armed  = 1'b0;
        m_active = 1'b1;
        m_s  = longint'(cyc) + 1;
        m_d  = longint'(delay_i);
        m_wm = (width_i == 0) ? 1 : longint'(width_i);
        per  = longint'(period_i);
        lo   = (per > m_wm) ? per - m_wm : 1;
        m_pp = m_wm + lo;
        n    = (count_i == 0) ? 1 : longint'(count_i);
        m_e  = m_s + m_d + (n - 1) * m_pp + m_wm;
      end
    end else if (arm_i) begin
      m_armed = 1'b1;
    end
    m_prev = trig_i;
    @(posedge clk_i);
    cyc++;
    if (m_active && longint'(cyc) >= m_e) begin
      m_active = 1'b0;
      m_done   = m_e;
    end
    #1;
    check("armed_o", 64'(armed_o), 64'(m_armed));
    check("busy_o",  64'(busy_o),  64'(m_active));
    check("pulse_o", 64'(pulse_o), 64'(exp_pulse(cyc)));
    check("done_o",  64'(done_o),  64'(longint'(cyc) == m_done));
    if (cyc < HMAX) begin
      h_pulse[cyc] = pulse_o;
      h_done[cyc]  = done_o;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_cfg(input int d, input int w, input int p, input int c);
    delay_i  = CNT_W'(d);
    width_i  = CNT_W'(w);
    period_i = CNT_W'(p);
    count_i  = RPT_W'(c);
  endtask

  // Arm with trig low, then present a rising edge; t0 is the edge cycle.
  task automatic arm_and_fire(output int t0);
    trig_i = 1'b0;
    arm_i  = 1'b1;
    step();
    arm_i  = 1'b0;
    trig_i = 1'b1;
    t0     = cyc;
    step();
  endtask

  function automatic logic [31:0] pvec(input int t0, input int n);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < n; k++) if (t0 + k < HMAX) v[k] = h_pulse[t0 + k];
    return v;
  endfunction

  function automatic logic [31:0] dvec(input int t0, input int n);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < n; k++) if (t0 + k < HMAX) v[k] = h_done[t0 + k];
    return v;
  endfunction

  initial begin
    int t0;
    model_reset();

    // Reset state while rst_ni is held low.
    repeat (2) @(posedge clk_i);
    #1;
    check("rst pulse_o", 64'(pulse_o), 64'd0);
    check("rst armed_o", 64'(armed_o), 64'd0);
    check("rst busy_o",  64'(busy_o),  64'd0);
    check("rst done_o",  64'(done_o),  64'd0);
    rst_ni = 1'b1;
    run(3);

    // Basic train: delay 3, width 2, period 5, count 3.
    set_cfg(3, 2, 5, 3);
    arm_and_fire(t0);
    trig_i = 1'b0;
    run(20);
    check("basic pulses", 64'(pvec(t0, 20)), 64'h0000_C630);
    check("basic done",   64'(dvec(t0, 20)), 64'h0001_0000);

    // Zero config: one single-cycle pulse immediately after the edge.
    set_cfg(0, 0, 7, 0);
    arm_and_fire(t0);
    trig_i = 1'b0;
    run(6);
    check("zero pulses", 64'(pvec(t0, 6)), 64'h2);
    check("zero done",   64'(dvec(t0, 6)), 64'h4);

    // Period not longer than width: forced one-cycle gap.
    set_cfg(0, 4, 2, 2);
    arm_and_fire(t0);
    trig_i = 1'b0;
    run(12);
    check("ovlp pulses", 64'(pvec(t0, 12)), 64'h3DE);
    check("ovlp done",   64'(dvec(t0, 12)), 64'h400);

    // Abort in the middle of the second pulse, then try to retrigger.
    set_cfg(1, 3, 6, 3);
    arm_and_fire(t0);
    trig_i = 1'b0;
    run(8);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      trig_i = ~trig_i;
      step();
    end
    check("abort pulses", 64'(pvec(t0, 20)), 64'h31C);
    check("abort done",   64'(dvec(t0, 20)), 64'h0);
    trig_i = 1'b0;
    run(2);

    // Trigger already high when armed: only a fresh edge fires.
    set_cfg(0, 1, 1, 1);
    trig_i = 1'b1;
    run(2);
    arm_i = 1'b1;
    t0 = cyc;
    step();
    arm_i = 1'b0;
    run(5);
    check("held no pulse", 64'(pvec(t0, 7)), 64'h0);
    trig_i = 1'b0;
    step();
    trig_i = 1'b1;
    t0 = cyc;
    step();
    run(5);
    check("held refire", 64'(pvec(t0, 6)), 64'h2);
    trig_i = 1'b0;
    run(2);

    // Extra trigger edges and config churn during the train.
    set_cfg(2, 2, 4, 3);
    arm_and_fire(t0);
    for (int i = 0; i < 15; i++) begin
      trig_i = ~trig_i;
      set_cfg($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
      step();
    end
    check("churn pulses", 64'(pvec(t0, 16)), 64'h1998);
    check("churn done",   64'(dvec(t0, 16)), 64'h2000);
    trig_i = 1'b0;
    run(2);

    // Asynchronous reset while the pulse is high.
    set_cfg(1, 4, 6, 2);
    arm_and_fire(t0);
    trig_i = 1'b0;
    step();
    check("pre-reset pulse_o", 64'(pulse_o), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async pulse_o", 64'(pulse_o), 64'd0);
    check("async busy_o",  64'(busy_o),  64'd0);
    check("async armed_o", 64'(armed_o), 64'd0);
    model_reset();
    repeat (2) @(posedge clk_i);
    cyc += 2;
    #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) begin
      trig_i = ~trig_i;
      step();
    end
    trig_i = 1'b0;
    run(2);

    // Randomized traffic against the timeline model.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) trig_i = ~trig_i;
      arm_i   = ($urandom_range(0, 7) == 0);
      abort_i = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0)
        set_cfg($urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 9), $urandom_range(0, 4));
      step();
    end
    arm_i   = 1'b0;
    abort_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pulse_sequencer
`default_nettype wire

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
Armed, trigger-driven pulse scheduler for the pt_feedback datapath. It detects a rising edge on a trigger input through an edge_detector instance. After a programmable delay it emits a programmable train of pulses (width, period, count) that gates downstream feedback/actuation logic. It sits between the trigger source (external or comparator) and the blocks it enables, and is configured from the register bank.

Parameters:
CNT_W, 32, width of delay/width/period counters and config inputs
RPT_W, 16, width of pulse-count config input and repeat counter

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset, asynchronous, active-low
trig_i  in  1  trigger level, synchronous to clk_i
arm_i  in  1  one-cycle arm request
abort_i  in  1  abort; highest priority
delay_i  in  CNT_W  cycles from trigger edge to first pulse
width_i  in  CNT_W  pulse high time in cycles (0 treated as 1)
period_i  in  CNT_W  pulse repetition period in cycles
count_i  in  RPT_W  number of pulses (0 treated as 1)
pulse_o  out  1  pulse train output
armed_o  out  1  high while waiting for trigger
busy_o  out  1  high from accepted trigger until train ends
done_o  out  1  one-cycle strobe after last pulse

Behaviour:
- Reset (async, rst_ni low): state IDLE, all counters 0, config shadow 0. pulse_o, armed_o, busy_o and done_o are 0.
- States: IDLE, ARMED, DELAY, HIGH, LOW. Outputs decode the registered state: armed_o = ARMED; busy_o = DELAY|HIGH|LOW; pulse_o = HIGH. done_o is a registered strobe.
- Edge detection: sub-module edge_detector on trig_i gives pe (combinational, same cycle as trig_i rising). It is always running, but pe is used only in ARMED.
- IDLE: arm_i -> ARMED next cycle. A pe in the same cycle as arm_i is ignored.
- ARMED: on pe at cycle T:
  - Latch delay_i, width_i, period_i and count_i into shadow registers. Later config changes do not affect the running train.
  - delay==0 -> HIGH at T+1. Otherwise -> DELAY at T+1, and the first HIGH cycle is T+1+delay.
- Trigger held high while arming produces no pulse; a fresh 0->1 edge is required.
- HIGH lasts max(width,1) cycles. Then:
  - If pulses remaining > 1 -> LOW.
  - Else -> IDLE with done_o=1 for exactly that one cycle.
- LOW lasts period-max(width,1) cycles, minimum 1. If period <= width, LOW is exactly 1 cycle (minimum gap guaranteed). Then -> HIGH.
- Repeat counter is loaded with max(count,1) at trigger and decremented at the end of each HIGH. Counters never wrap: all-ones values run to full length.
- Trigger edges in DELAY/HIGH/LOW/IDLE are ignored (no retrigger, no queueing).
- Single-shot: after done, the block returns to IDLE and needs a new arm_i.
- abort_i, any state -> IDLE next cycle:
  - pulse_o falls next cycle; no done_o.
  - abort_i wins over a simultaneous arm_i or pe.
- arm_i while busy or armed is ignored.
- Async reset mid-train forces pulse_o low immediately (async).
- Arithmetic: unsigned compare only; LOW length is computed from shadow registers at trigger time, CNT_W bits, saturating at 1.

Decomposition:
- Shared package pt_feedback_pkg: state enum (IDLE, ARMED, DELAY, HIGH, LOW, 3 bits) and default CNT_W/RPT_W constants.
- One sub-module: edge_detector (existing) for trig_i.
- The FSM and counters stay in pulse_sequencer.

Test Plan:
- Basic: arm; trig rises at T; delay=3, width=2, period=5, count=3.
  - pulse_o high T+4..T+5, T+9..T+10, T+14..T+15.
  - done_o high at T+16; busy_o low from T+16.
- Zero config: delay=0, width=0, count=0.
  - Single 1-cycle pulse at T+1; done_o at T+2.
- Period<=width: width=4, period=2, count=2.
  - pulse_o high 4 cycles, low 1 cycle, high 4 cycles.
- Abort: abort mid second pulse.
  - pulse_o low next cycle; state IDLE; done_o never asserts.
  - A subsequent trig edge produces nothing until re-arm.
- Edge rules:
  - trig already high when arm_i pulses -> no pulse until trig falls and rises again.
  - Extra trig edges during the train -> train unchanged.
  - Config changed mid-train -> timing unchanged.
- Reset: drop rst_ni during HIGH.
  - pulse_o, busy_o and armed_o go 0 immediately without a clock.
  - After release, the block idles until arm_i.
